// File: rtl/rbfifo_pkg.sv
// Shared helpers for the parametrised ring-buffer FIFO: address-width helper
// and the parameter legality predicate evaluated when the top elaborates.
package rbfifo_pkg;

    // Constant-evaluable ceiling log2, usable in parameter and port declarations.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

    function automatic bit is_pow2(input int value);
        return (value > 0) && ((value & (value - 1)) == 0);
    endfunction

    // Legal shape: power-of-two depth of at least 2, and the almost-empty
    // watermark strictly below the almost-full one, which fits in the FIFO.
    function automatic bit params_legal(input int depth, input int ae_level, input int af_level);
        return (depth >= 2) && is_pow2(depth) && (ae_level < af_level) && (af_level <= depth);
    endfunction

endpackage

// File: rtl/rbfifo_param_if.sv
// Producer/consumer-facing signal bundle of the FIFO; the producer/consumer
// side drives requests through master, the FIFO reports through slave.
interface rbfifo_param_if
    import rbfifo_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
);
    localparam int AW = clog2(DEPTH);

    logic [WIDTH-1:0] dataIn;
    logic             push;
    logic             pop;
    logic             clearErr;
    logic [WIDTH-1:0] dataOut;
    logic             full;
    logic             empty;
    logic             almostFull;
    logic             almostEmpty;
    logic [AW:0]      count;
    logic             overflow;
    logic             underflow;

    modport master (
        output dataIn, push, pop, clearErr,
        input  dataOut, full, empty, almostFull, almostEmpty, count, overflow, underflow
    );

    modport slave (
        input  dataIn, push, pop, clearErr,
        output dataOut, full, empty, almostFull, almostEmpty, count, overflow, underflow
    );

endinterface

// File: rtl/rbfifo_mem.sv
// DEPTH x WIDTH storage: one synchronous write port, one asynchronous read
// port so the head word falls through to the FIFO output without a request.
module rbfifo_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clock,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    // Contents are deliberately left unreset; the top masks the read port while empty.
    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clock) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/rbfifo_param.sv
// Parametrised fall-through ring-buffer FIFO with occupancy, watermark flags
// and sticky overflow/underflow flags; pointers carry an extra wrap bit.
module rbfifo_param
    import rbfifo_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic           clock,
    input  logic           reset_n,
    rbfifo_param_if.slave  bus
);

    localparam int AW = clog2(DEPTH);
    localparam logic [AW:0] AF_CNT = AF_LEVEL[AW:0];
    localparam logic [AW:0] AE_CNT = AE_LEVEL[AW:0];

    generate
        if (!params_legal(DEPTH, AE_LEVEL, AF_LEVEL)) begin : g_bad_params
            $error("rbfifo_param: DEPTH must be a power of two >= 2 and AE_LEVEL < AF_LEVEL <= DEPTH");
        end
    endgenerate

    logic [AW:0]      r_head;
    logic [AW:0]      r_tail;
    logic             r_overflow;
    logic             r_underflow;

    logic [AW:0]      w_count;
    logic             w_empty;
    logic             w_full;
    logic             w_push_ok;
    logic             w_pop_ok;
    logic             w_ovf_evt;
    logic             w_unf_evt;
    logic [WIDTH-1:0] w_rdata;

    assign w_count = r_head - r_tail;
    assign w_empty = (r_head == r_tail);
    assign w_full  = (r_head[AW-1:0] == r_tail[AW-1:0]) && (r_head[AW] != r_tail[AW]);

    // A pop in the same cycle frees the slot being written, so a full FIFO still takes the push.
    assign w_push_ok = bus.push & (~w_full | bus.pop);
    assign w_pop_ok  = bus.pop & ~w_empty;
    assign w_ovf_evt = bus.push & w_full & ~bus.pop;
    assign w_unf_evt = bus.pop & w_empty;

    rbfifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clock   (clock),
        .i_we    (w_push_ok),
        .i_waddr (r_head[AW-1:0]),
        .i_wdata (bus.dataIn),
        .i_raddr (r_tail[AW-1:0]),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_head      <= '0;
            r_tail      <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_head <= r_head + 1'b1;
            end
            if (w_pop_ok) begin
                r_tail <= r_tail + 1'b1;
            end
            // A fresh error outranks clearErr in the same cycle.
            r_overflow  <= w_ovf_evt | (r_overflow  & ~bus.clearErr);
            r_underflow <= w_unf_evt | (r_underflow & ~bus.clearErr);
        end
    end

    assign bus.dataOut     = w_empty ? '0 : w_rdata;
    assign bus.full        = w_full;
    assign bus.empty       = w_empty;
    assign bus.count       = w_count;
    assign bus.almostFull  = (w_count >= AF_CNT);
    assign bus.almostEmpty = (w_count <= AE_CNT);
    assign bus.overflow    = r_overflow;
    assign bus.underflow   = r_underflow;

endmodule

// File: doc/rbfifo_param.md
# rbfifo_param

Parametrised ring-buffer FIFO, next generation of the team's fixed 4-bit × 16 ring buffer. Width, depth, and watermarks are parameters. Push and pop are accepted in the same cycle, and the FIFO exposes occupancy, almost-full/almost-empty flags and sticky overflow/underflow error flags. It sits between producer and consumer logic in the same clock domain. Read data falls through to the output, so the head word is visible without a read request.

## Interface
- `WIDTH`, 8: data word width in bits.
- `DEPTH`, 16: number of entries; must be a power of two, ≥ 2.
- `AF_LEVEL`, DEPTH-2: `almostFull` asserts when count ≥ AF_LEVEL.
- `AE_LEVEL`, 2: `almostEmpty` asserts when count ≤ AE_LEVEL.
- `AW`: derived, $clog2(DEPTH); not overridable.

Ports:
- `clock`  in  1: single clock, rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `dataIn`  in  WIDTH: write data.
- `push`  in  1: write request.
- `pop`  in  1: read request; consumes the word on `dataOut`.
- `clearErr`  in  1: synchronous clear of sticky error flags.
- `dataOut`  out  WIDTH: oldest entry; 0 when empty.
- `full`  out  1: count == DEPTH.
- `empty`  out  1: count == 0.
- `almostFull`  out  1: count ≥ AF_LEVEL.
- `almostEmpty`  out  1: count ≤ AE_LEVEL.
- `count`  out  AW+1: current occupancy, 0..DEPTH.
- `overflow`  out  1: sticky; a push was dropped.
- `underflow`  out  1: sticky; a pop was dropped.

## Operation
**Pointers and flags**
- `head` and `tail` are AW+1 bits wide; the extra MSB is the wrap bit.
- Storage index is ptr[AW-1:0]. Pointers increment modulo 2^(AW+1).
- `empty` = (head == tail).
- `full` = index bits equal and wrap bits differ.
- `count` = head − tail, computed in AW+1 bits. It is registered, or derived combinationally from the registered pointers.

**Accept rules**
- Effective push: pushOk = push & (~full | pop).
- Effective pop: popOk = pop & ~empty.
- When full, push & pop: both are accepted. The write goes to the slot being vacated, `dataOut` shows the old word that cycle, and count stays at DEPTH.
- When empty, push & pop: push only. Pop is dropped and `underflow` sets.
- Otherwise push & pop: both are accepted and count is unchanged.

**Memory**
- pushOk writes mem[head index] ← dataIn and increments head.
- popOk increments tail.

**Error flags**
- `overflow` sets on push & full & ~pop.
- `underflow` sets on pop & empty.
- `clearErr` clears both flags. A new error in the same cycle as `clearErr` wins, so the flag stays set.

**Reset**
- head = tail = 0 and both error flags = 0.
- Outputs during reset: empty=1, full=0, count=0, almostEmpty=1, almostFull=0, dataOut=0.
- Memory contents are not reset; they are never visible, because `dataOut` is masked to 0 when empty.
- Reset asserted mid-operation discards all contents immediately, asynchronously.

## Timing
- Write-to-visible latency is 1 cycle: a word pushed into an empty FIFO at edge N appears on `dataOut` after edge N, with empty=0.
- `dataOut` is combinational from mem[tail index]. It updates in the cycle after each popOk.
- `full`, `empty`, `count` and the watermark flags reflect state after the most recent edge. No lookahead.
- Error flags set at the edge following the offending request.
- Reset deassertion is synchronous to `clock`; the first push is accepted at the first edge after `reset_n` rises.

## Structure
- Package `rbfifo_pkg` holds:
  - a `clog2` helper function;
  - parameter legality checks (DEPTH power of two, AE_LEVEL < AF_LEVEL ≤ DEPTH) as elaboration-time assertions.
- Sub-module `rbfifo_mem`: DEPTH×WIDTH storage with one synchronous write port and one asynchronous read port.
- Pointer, flag and error logic live in the top module.

## Test plan
All scenarios use DEPTH=4, WIDTH=8, AF_LEVEL=3, AE_LEVEL=1.
- **Fill:** reset, then push 0x11,0x22,0x33,0x44. Count goes 1,2,3,4; almostFull rises at count 3; full=1 after the 4th push. A 5th push with pop=0 sets overflow and leaves contents unchanged.
- **Drain:** from full, pop ×4. dataOut shows 0x11,0x22,0x33,0x44 in order, then 0 with empty=1. A further pop sets underflow.
- **Simultaneous push/pop when full:** push 0x55 with pop. dataOut=0x11 that cycle, count stays 4, and overflow stays 0. Draining then yields 0x22,0x33,0x44,0x55.
- **Simultaneous push/pop when empty:** push 0xAA with pop. Count becomes 1, dataOut=0xAA, underflow=1.
- **Wrap-around:** 10 cycles of push+pop at count 2. FIFO order is preserved and full/empty are never falsely asserted across the pointer wrap.
- **Reset and clear:** assert reset_n=0 mid-stream at count 3. Outputs go to reset values immediately, without waiting for a clock edge. Afterwards, clearErr concurrent with a new overflow leaves overflow=1.
